// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS unified memory port: FSM encoding,
// owner select convention and default timing parameters.
package mips_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Owner values double as the address-mux select (0 = data1, 1 = data2).
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;

  localparam int LAT_W    = 4;
  localparam int STARVE_W = 8;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: sel 0 selects data1, sel 1 selects data2.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? data2 : data1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// access: one transaction in flight, DM priority with an IF starvation guard.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_sel,
  input  logic [31:0] mem_rdata
);

  state_e                state_q;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  owner_q;
  logic                  we_q;

  logic force_if;
  logic win_dm;
  logic grant;
  logic resp;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    force_if = if_req && (starve_q == STARVE_W'(STARVE_MAX));
    win_dm   = dm_req && !force_if;
    grant    = (state_q == ST_IDLE) && (if_req || dm_req);
    resp     = (state_q == ST_BUSY) && (cnt_q == LAT_W'(MEM_LAT));

    cnt_d    = cnt_q + LAT_W'(1);
    starve_d = starve_q;
    if (grant) begin
      cnt_d    = LAT_W'(1);
      // Only a DM grant that overtook a waiting fetch counts toward starvation.
      starve_d = (win_dm && if_req) ? starve_q + STARVE_W'(1) : '0;
    end
  end

  always_comb begin
    if_gnt    = grant && !win_dm;
    dm_gnt    = grant && win_dm;
    mem_en    = grant;
    mem_we    = grant && win_dm && dm_we;
    mem_wdata = (grant && win_dm) ? dm_wdata : '0;
    mem_sel   = grant ? win_dm : owner_q;

    if_rvalid = resp && (owner_q == OWN_IF);
    dm_rvalid = resp && (owner_q == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !we_q) ? mem_rdata : '0;
  end

  mux2 #(.WIDTH(32)) u_addr_mux (
    .data1 (if_addr),
    .data2 (dm_addr),
    .sel   (mem_sel),
    .y     (mem_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q  <= ST_BUSY;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= win_dm;
            we_q     <= win_dm && dm_we;
          end
        end
        ST_BUSY: begin
          if (resp) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a timeline model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_sel;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are read mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (MEM_LAT + 2) step();
  endtask

  // Timeline model: a grant at cycle g owns the port until its response at
  // cycle g+MEM_LAT; the port is free again from the following cycle.
  bit          armed = 1'b0;
  bit          in_flight = 1'b0;
  int          cyc = 0;
  int          resp_cyc = 0;
  bit          own_dm = 1'b0;
  bit          own_we = 1'b0;
  int          starve = 0;
  bit          last_sel = 1'b0;

  always @(negedge clk) begin
    bit          req_any, win_dm_m, gnt_m, resp_m, sel_m;
    logic [31:0] exp_if_rdata, exp_dm_rdata;

    req_any  = if_req || dm_req;
    gnt_m    = !in_flight && req_any;
    win_dm_m = dm_req && !(if_req && starve == STARVE_MAX);
    resp_m   = in_flight && (cyc == resp_cyc);
    sel_m    = gnt_m ? win_dm_m : last_sel;
    exp_if_rdata = (resp_m && !own_dm) ? mem_rdata : 32'h0;
    exp_dm_rdata = (resp_m && own_dm && !own_we) ? mem_rdata : 32'h0;

    if (armed) begin
      check("if_gnt",    {31'h0, if_gnt},    {31'h0, gnt_m && !win_dm_m});
      check("dm_gnt",    {31'h0, dm_gnt},    {31'h0, gnt_m && win_dm_m});
      check("mem_en",    {31'h0, mem_en},    {31'h0, gnt_m});
      check("mem_we",    {31'h0, mem_we},    {31'h0, gnt_m && win_dm_m && dm_we});
      check("mem_sel",   {31'h0, mem_sel},   {31'h0, sel_m});
      check("mem_addr",  mem_addr,           sel_m ? dm_addr : if_addr);
      if (gnt_m && win_dm_m && dm_we)
        check("mem_wdata", mem_wdata, dm_wdata);
      check("if_rvalid", {31'h0, if_rvalid}, {31'h0, resp_m && !own_dm});
      check("dm_rvalid", {31'h0, dm_rvalid}, {31'h0, resp_m && own_dm});
      check("if_rdata",  if_rdata,           exp_if_rdata);
      check("dm_rdata",  dm_rdata,           exp_dm_rdata);
    end

    if (reset) begin
      armed     = 1'b1;
      in_flight = 1'b0;
      starve    = 0;
      last_sel  = 1'b0;
    end else begin
      if (resp_m) in_flight = 1'b0;
      if (gnt_m) begin
        in_flight = 1'b1;
        resp_cyc  = cyc + MEM_LAT;
        own_dm    = win_dm_m;
        own_we    = win_dm_m && dm_we;
        last_sel  = win_dm_m;
        starve    = (win_dm_m && if_req) ? starve + 1 : 0;
      end
    end
    cyc++;
  end

  initial begin
    bit gi, gd;

    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;
    repeat (3) step();
    sample();
    check("rst if_gnt", {31'h0, if_gnt}, 32'h0);
    check("rst mem_en", {31'h0, mem_en}, 32'h0);
    check("rst mem_sel", {31'h0, mem_sel}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Single fetch
    if_req = 1'b1; if_addr = 32'h0040_0000;
    sample();
    check("fetch if_gnt",   {31'h0, if_gnt},  32'h1);
    check("fetch mem_en",   {31'h0, mem_en},  32'h1);
    check("fetch mem_sel",  {31'h0, mem_sel}, 32'h0);
    check("fetch mem_addr", mem_addr,         32'h0040_0000);
    step(); if_req = 1'b0;
    sample();
    check("fetch busy mem_en", {31'h0, mem_en}, 32'h0);
    step(); mem_rdata = 32'h8C08_0004;
    sample();
    check("fetch if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check("fetch if_rdata",  if_rdata,           32'h8C08_0004);
    step(); if_req = 1'b1;
    sample();
    check("fetch regrant", {31'h0, if_gnt}, 32'h1);
    step();
    drain();

    // Contention: DM load wins, IF follows
    if_req = 1'b1; if_addr = 32'h0040_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
    sample();
    check("cont dm_gnt",   {31'h0, dm_gnt}, 32'h1);
    check("cont if_gnt0",  {31'h0, if_gnt}, 32'h0);
    check("cont mem_addr", mem_addr,        32'h1001_0000);
    step(); dm_req = 1'b0;
    step(); mem_rdata = 32'h1234_5678;
    sample();
    check("cont dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
    check("cont dm_rdata",  dm_rdata,           32'h1234_5678);
    step();
    sample();
    check("cont if_gnt3", {31'h0, if_gnt},  32'h1);
    check("cont sel3",    {31'h0, mem_sel}, 32'h0);
    step(); if_req = 1'b0;
    step(); mem_rdata = 32'hCAFE_0001;
    sample();
    check("cont if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check("cont if_rdata",  if_rdata,           32'hCAFE_0001);
    step();
    drain();

    // Store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0008; dm_wdata = 32'hDEAD_BEEF;
    sample();
    check("store mem_we",    {31'h0, mem_we},  32'h1);
    check("store mem_wdata", mem_wdata,        32'hDEAD_BEEF);
    check("store mem_sel",   {31'h0, mem_sel}, 32'h1);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    step(); mem_rdata = 32'h5555_AAAA;
    sample();
    check("store dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
    check("store dm_rdata",  dm_rdata,           32'h0);
    step();
    drain();

    // Starvation: four DM grants, then IF, then DM again
    if_req = 1'b1; if_addr = 32'h0040_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0100;
    for (int c = 0; c < 16; c++) begin
      sample();
      check($sformatf("starve dm_gnt c%0d", c), {31'h0, dm_gnt},
            {31'h0, (c == 0 || c == 3 || c == 6 || c == 9 || c == 15)});
      check($sformatf("starve if_gnt c%0d", c), {31'h0, if_gnt}, {31'h0, (c == 12)});
      step();
    end
    drain();

    // Reset mid-transaction drops the response
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0020;
    sample();
    check("rstmid dm_gnt", {31'h0, dm_gnt}, 32'h1);
    step(); dm_req = 1'b0; reset = 1'b1;
    step(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h0040_0200;
    sample();
    check("rstmid dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
    check("rstmid if_gnt",    {31'h0, if_gnt},    32'h1);
    check("rstmid mem_en",    {31'h0, mem_en},    32'h1);
    step();
    drain();

    // Stall then drop: no grant issued for the dropped fetch
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0030;
    step(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h0040_0300;
    sample();
    check("stall if_gnt", {31'h0, if_gnt}, 32'h0);
    step(); if_req = 1'b0;
    sample();
    check("stall dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
    check("stall if_gnt2",   {31'h0, if_gnt},    32'h0);
    step();
    sample();
    check("drop mem_en", {31'h0, mem_en}, 32'h0);
    check("drop if_gnt", {31'h0, if_gnt}, 32'h0);
    step();
    drain();

    // Randomized traffic; requesters hold until granted, occasionally drop
    for (int n = 0; n < 3000; n++) begin
      sample();
      gi = if_gnt;
      gd = dm_gnt;
      step();
      if (if_req && !gi && $urandom_range(99) < 3) begin
        if_req = 1'b0;
      end else if ((if_req && gi) || (!if_req && $urandom_range(99) < 40)) begin
        if_req  = ($urandom_range(99) < 60);
        if_addr = {$urandom} & 32'hFFFF_FFFC;
      end
      if (dm_req && !gd && $urandom_range(99) < 3) begin
        dm_req = 1'b0;
      end else if ((dm_req && gd) || (!dm_req && $urandom_range(99) < 40)) begin
        dm_req   = ($urandom_range(99) < 60);
        dm_we    = $urandom_range(1) == 1;
        dm_addr  = {$urandom} & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
